// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder
// Purpose  : Byte-wide memory responder at the far end of the CPU memory bus.
//            One request per cycle. A read returns its byte on data_out one
//            cycle later. addr_in[17]=0 selects the on-chip byte RAM.
//            addr_in[17]=1 selects the I/O window, which holds a TX FIFO, an
//            optional RX FIFO and a halt register.
//            I/O map, decoded by addr_in[2:0]:
//              0 : write pushes the TX FIFO; read pops the RX FIFO
//              4 : write sets halt; read returns RX non-empty
//              other offsets : reads return 0x00, writes do nothing
// Config   : `RAM_IO_RESPONDER_RX_EN enables the RX FIFO. When it is not
//            defined, rx_data/rx_valid are ignored and the I/O reads at
//            offsets 0 and 4 return 0x00.
// Ports    : clk, rst        clock; synchronous active-high reset
//            addr_in[31:0]   byte address of the request
//            r_nw_in         0 = read, 1 = write
//            data_in[7:0]    write byte
//            data_out[7:0]   read byte for the request of the previous edge
//            tx_data/tx_valid/tx_ready  first-word-fall-through TX stream
//            rx_data/rx_valid           incoming RX byte stream
//            io_full         registered TX back-pressure flag
//            tx_overflow     sticky flag: a TX write was dropped
//            halt            sticky flag: the halt register was written
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_LOG   = 3,
  parameter int RX_DEPTH_LOG   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic        r_nw_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        io_full,
  output logic        tx_overflow,
  output logic        halt
);

  // TX FIFO constants
  localparam logic [TX_DEPTH_LOG:0]   c_TX_FULL    = {1'b1, {TX_DEPTH_LOG{1'b0}}};
  localparam logic [TX_DEPTH_LOG:0]   c_TX_HI      = c_TX_FULL - {{(TX_DEPTH_LOG-1){1'b0}}, 2'd2};
  localparam logic [TX_DEPTH_LOG-1:0] c_TX_PTR_ONE = {{(TX_DEPTH_LOG-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic                      w_is_io;
  logic [2:0]                w_io_off;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
  logic                      w_io_wr0;
  logic                      w_io_rd0;
  logic                      w_io_wr4;
  logic                      w_unused_addr;

  assign w_is_io   = addr_in[17];
  assign w_io_off  = addr_in[2:0];
  assign w_ram_idx = addr_in[RAM_ADDR_WIDTH-1:0];
  assign w_io_wr0  = w_is_io &&  r_nw_in && (w_io_off == 3'd0);
  assign w_io_rd0  = w_is_io && !r_nw_in && (w_io_off == 3'd0);
  assign w_io_wr4  = w_is_io &&  r_nw_in && (w_io_off == 3'd4);
  // Address bits outside the decode are deliberately don't-care.
  assign w_unused_addr = ^addr_in;

  // --------------------------------------------------------------------------
  // Byte RAM: contents are not reset and persist across rst.
  // --------------------------------------------------------------------------
  logic [7:0] r_ram [0:(1 << RAM_ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (!rst && !w_is_io && r_nw_in) begin
      r_ram[w_ram_idx] <= data_in;
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]              r_tx_mem [0:(1 << TX_DEPTH_LOG)-1];
  logic [TX_DEPTH_LOG-1:0] r_tx_head;
  logic [TX_DEPTH_LOG-1:0] r_tx_tail;
  logic [TX_DEPTH_LOG:0]   r_tx_count;
  logic                    w_tx_pop;
  logic                    w_tx_push;
  logic                    w_tx_drop;
  logic [TX_DEPTH_LOG:0]   w_tx_count_nxt;

  assign tx_valid  = (r_tx_count != '0);
  assign tx_data   = r_tx_mem[r_tx_head];
  assign w_tx_pop  = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // only fails when nothing leaves.
  assign w_tx_push = w_io_wr0 && ((r_tx_count != c_TX_FULL) || w_tx_pop);
  assign w_tx_drop = w_io_wr0 && !w_tx_push;
  assign w_tx_count_nxt = r_tx_count
                        + {{TX_DEPTH_LOG{1'b0}}, w_tx_push}
                        - {{TX_DEPTH_LOG{1'b0}}, w_tx_pop};

  always_ff @(posedge clk) begin
    if (!rst && w_tx_push) begin
      r_tx_mem[r_tx_tail] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_head  <= '0;
      r_tx_tail  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_tail <= r_tx_tail + c_TX_PTR_ONE;
      if (w_tx_pop)  r_tx_head <= r_tx_head + c_TX_PTR_ONE;
      r_tx_count <= w_tx_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Flags. io_full asserts two entries early so the initiator's in-flight
  // requests still fit after it observes the flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      io_full     <= 1'b0;
      tx_overflow <= 1'b0;
      halt        <= 1'b0;
    end else begin
      io_full <= (w_tx_count_nxt >= c_TX_HI);
      if (w_tx_drop) tx_overflow <= 1'b1;
      if (w_io_wr4)  halt        <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO and I/O read data
  // --------------------------------------------------------------------------
  logic [7:0] w_io_rd_byte;

`ifdef RAM_IO_RESPONDER_RX_EN
  localparam logic [RX_DEPTH_LOG:0]   c_RX_FULL    = {1'b1, {RX_DEPTH_LOG{1'b0}}};
  localparam logic [RX_DEPTH_LOG-1:0] c_RX_PTR_ONE = {{(RX_DEPTH_LOG-1){1'b0}}, 1'b1};

  logic [7:0]              r_rx_mem [0:(1 << RX_DEPTH_LOG)-1];
  logic [RX_DEPTH_LOG-1:0] r_rx_head;
  logic [RX_DEPTH_LOG-1:0] r_rx_tail;
  logic [RX_DEPTH_LOG:0]   r_rx_count;
  logic                    w_rx_nonempty;
  logic                    w_rx_pop;
  logic                    w_rx_push;

  assign w_rx_nonempty = (r_rx_count != '0);
  // A read of an empty FIFO returns 0x00 and does not pop.
  assign w_rx_pop      = w_io_rd0 && w_rx_nonempty;
  assign w_rx_push     = rx_valid && (r_rx_count != c_RX_FULL);

  always_ff @(posedge clk) begin
    if (!rst && w_rx_push) begin
      r_rx_mem[r_rx_tail] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_head  <= '0;
      r_rx_tail  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_tail <= r_rx_tail + c_RX_PTR_ONE;
      if (w_rx_pop)  r_rx_head <= r_rx_head + c_RX_PTR_ONE;
      r_rx_count <= r_rx_count
                  + {{RX_DEPTH_LOG{1'b0}}, w_rx_push}
                  - {{RX_DEPTH_LOG{1'b0}}, w_rx_pop};
    end
  end

  always_comb begin
    w_io_rd_byte = 8'h00;
    if (w_io_off == 3'd0) begin
      if (w_rx_nonempty) w_io_rd_byte = r_rx_mem[r_rx_head];
    end else if (w_io_off == 3'd4) begin
      w_io_rd_byte = {7'b0, w_rx_nonempty};
    end
  end
`else
  logic w_unused_rx;
  assign w_unused_rx  = ^{rx_data, rx_valid, w_io_rd0};
  assign w_io_rd_byte = 8'h00;
`endif

  // --------------------------------------------------------------------------
  // Read data register: updated on reads only, held across writes.
  // A read issued while rst is high is discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (!r_nw_in) begin
      if (!w_is_io) data_out <= r_ram[w_ram_idx];
      else          data_out <= w_io_rd_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_io_responder
// Purpose  : Scoreboard bench for ram_io_responder. The driver applies one
//            request per cycle, advances a queue/array reference model and
//            queues the expected post-edge outputs. A monitor pops one entry
//            per cycle and compares it with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in;
  logic        r_nw_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        io_full;
  logic        tx_overflow;
  logic        halt;

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .r_nw_in(r_nw_in),
    .data_in(data_in), .data_out(data_out), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .io_full(io_full), .tx_overflow(tx_overflow),
    .halt(halt)
  );

  // ---------------- reference model ----------------
  localparam int TXD = 8;
  localparam int RXD = 8;

  typedef struct {
    logic [7:0] dout;
    logic       txv;
    logic [7:0] txd;
    logic       full;
    logic       ovf;
    logic       hlt;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  m_ram [int];
  logic [16:0] wr_keys[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  m_dout;
  logic        m_ovf;
  logic        m_halt;

  int checks = 0;
  int errors = 0;

  // One bus cycle: drive at the falling edge, advance the model, queue
  // what the DUT must show after the next rising edge.
  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [7:0] d, input logic txr,
                       input logic [7:0] rxd, input logic rxv);
    logic [7:0] rdv;
    logic       txpop, txwr, rxpop;
    int         rxpre;
    exp_t       e;
    @(negedge clk);
    rst = r; addr_in = a; r_nw_in = w; data_in = d;
    tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    if (r) begin
      tx_q.delete(); rx_q.delete();
      m_dout = 8'h00; m_ovf = 1'b0; m_halt = 1'b0;
    end else begin
      rdv   = 8'h00;
      txwr  = 1'b0;
      rxpop = 1'b0;
      txpop = txr && (tx_q.size() > 0);
      rxpre = rx_q.size();
      if (!a[17]) begin
        if (w) begin
          m_ram[int'(a[16:0])] = d;
          wr_keys.push_back(a[16:0]);
        end else if (m_ram.exists(int'(a[16:0]))) begin
          rdv = m_ram[int'(a[16:0])];
        end
      end else if (a[2:0] == 3'd0) begin
        if (w) txwr = 1'b1;
`ifdef RAM_IO_RESPONDER_RX_EN
        else if (rxpre > 0) begin rdv = rx_q[0]; rxpop = 1'b1; end
`endif
      end else if (a[2:0] == 3'd4) begin
        if (w) m_halt = 1'b1;
`ifdef RAM_IO_RESPONDER_RX_EN
        else rdv = (rxpre > 0) ? 8'h01 : 8'h00;
`endif
      end
      if (!w) m_dout = rdv;
      if (txpop) void'(tx_q.pop_front());
      if (txwr) begin
        if (tx_q.size() < TXD) tx_q.push_back(d);
        else m_ovf = 1'b1;
      end
`ifdef RAM_IO_RESPONDER_RX_EN
      if (rxpop) void'(rx_q.pop_front());
      if (rxv && rxpre < RXD) rx_q.push_back(rxd);
`endif
    end
    e.dout = m_dout;
    e.txv  = (tx_q.size() > 0);
    e.txd  = e.txv ? tx_q[0] : 8'h00;
    e.full = (tx_q.size() >= TXD - 2);
    e.ovf  = m_ovf;
    e.hlt  = m_halt;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic txr);
    drive(1'b0, a, 1'b1, d, txr, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic txr);
    drive(1'b0, a, 1'b0, 8'h00, txr, 8'h00, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data_out",    data_out,           e.dout);
      check("tx_valid",    {7'b0, tx_valid},    {7'b0, e.txv});
      if (e.txv) check("tx_data", tx_data, e.txd);
      check("io_full",     {7'b0, io_full},     {7'b0, e.full});
      check("tx_overflow", {7'b0, tx_overflow}, {7'b0, e.ovf});
      check("halt",        {7'b0, halt},        {7'b0, e.hlt});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] hi;
    logic [16:0] k;
    int          sel;
    rst = 1'b1; addr_in = '0; r_nw_in = 1'b0; data_in = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset, then make address 0 a known idle read.
    drive(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    wr(32'h0, 8'h00, 1'b0);

    // RAM write then read next cycle; second address preloaded.
    wr(32'h00010, 8'hA5, 1'b0);
    rd(32'h00010, 1'b0);
    wr(32'h00011, 8'h3C, 1'b0);
    rd(32'h00000, 1'b0);
    rd(32'h00011, 1'b0);
    wr(32'h00012, 8'h77, 1'b0);    // write holds previous data_out

    // TX: three bytes held, then drained.
    wr(32'h30000, 8'h41, 1'b0);
    wr(32'h30000, 8'h42, 1'b0);
    wr(32'h30000, 8'h43, 1'b0);
    rd(32'h0, 1'b0);
    for (int i = 0; i < 4; i++) rd(32'h0, 1'b1);

    // TX full and overflow, then drain past io_full threshold.
    for (int i = 0; i < 9; i++) wr(32'h30000, 8'h50 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) rd(32'h0, 1'b1);

    // Full FIFO: push with simultaneous pop succeeds.
    for (int i = 0; i < 8; i++) wr(32'h30000, 8'h60 + 8'(i), 1'b0);
    wr(32'h30000, 8'h6F, 1'b1);
    for (int i = 0; i < 9; i++) rd(32'h0, 1'b1);

    // RX byte then status/data reads.
    drive(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h7E, 1'b1);
    rd(32'h30004, 1'b0);
    rd(32'h30000, 1'b0);
    rd(32'h30004, 1'b0);
    rd(32'h30000, 1'b0);
    // Pop of an empty FIFO while pushing.
    drive(1'b0, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1);
    rd(32'h30000, 1'b0);

    // Reset during a read: discarded, RAM persists.
    wr(32'h30000, 8'h11, 1'b0);
    drive(1'b1, 32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rd(32'h00010, 1'b0);

    // Halt and unused offsets.
    wr(32'h30004, 8'h00, 1'b0);
    rd(32'h0, 1'b0);
    wr(32'h30002, 8'hFF, 1'b0);
    rd(32'h30002, 1'b0);
    rd(32'h30006, 1'b0);

    // Clear halt before the random phase.
    drive(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomized traffic; upper address bits randomized to prove they are ignored.
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 199);
      hi  = $urandom;
      hi[17:0] = '0;
      a   = $urandom;
      if (sel == 0) begin
        drive(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      end else if (sel < 70 || wr_keys.size() == 0) begin
        a[17] = 1'b0;
        drive(1'b0, a, 1'b1, 8'($urandom), ($urandom_range(0, 3) != 0),
              8'($urandom), ($urandom_range(0, 3) == 0));
      end else if (sel < 130) begin
        k = wr_keys[$urandom_range(0, wr_keys.size() - 1)];
        drive(1'b0, hi | {15'b0, k}, 1'b0, 8'h00, ($urandom_range(0, 3) != 0),
              8'($urandom), ($urandom_range(0, 3) == 0));
      end else if (sel < 170) begin
        drive(1'b0, hi | 32'h20000, 1'b1, 8'($urandom), ($urandom_range(0, 2) == 0),
              8'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        a = hi | 32'h20000 | {29'b0, 3'($urandom)};
        if (a[2:0] == 3'd4 && $urandom_range(0, 9) != 0) a[2:0] = 3'd0;
        drive(1'b0, a, ($urandom_range(0, 3) == 0), 8'($urandom),
              ($urandom_range(0, 1) == 0), 8'($urandom), ($urandom_range(0, 1) == 0));
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
